// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for mem_arbiter: access modes, memory state codes,
// arbiter state and owner encodings.
package mem_arbiter_pkg;

    localparam logic [1:0] MODE_SB = 2'b00;
    localparam logic [1:0] MODE_SH = 2'b01;
    localparam logic [1:0] MODE_SW = 2'b10;

    localparam logic [1:0] MEMORY_STATE_OK        = 2'b00;
    localparam logic [1:0] MEMORY_STATE_ALIGNMENT = 2'b01;
    localparam logic [1:0] MEMORY_STATE_FAULT     = 2'b10;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // True when an access of the given size is not naturally aligned.
    function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] mode);
        return ((mode == MODE_SH) && addr[0]) || ((mode == MODE_SW) && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around mem_arbiter.
// slave: arbiter view; master: core + memory view.
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_mode;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_w_addr;
    logic [1:0]  mem_r_mode;
    logic [1:0]  mem_w_mode;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic [1:0]  mem_state;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_r_data, mem_state,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_r_mode, mem_w_mode, mem_w_data,
        output busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_r_data, mem_state,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_r_mode, mem_w_mode, mem_w_data,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_arbiter. MEM_ARBITER_RR_EN selects
// round-robin on last_owner; otherwise data wins unless fetch is starved.
module mem_arb_pick
    import mem_arbiter_pkg::*;
`ifndef MEM_ARBITER_RR_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef MEM_ARBITER_RR_EN
    input  owner_e last_owner,
`else
    input  logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt,
`endif
    output logic   pick_fetch,
    output logic   pick_data
);

    logic fetch_first;

`ifdef MEM_ARBITER_RR_EN
    assign fetch_first = (last_owner == OWN_DATA);
`else
    assign fetch_first = (starve_cnt == ($clog2(STARVE_LIMIT+1))'(STARVE_LIMIT));
`endif

    always_comb begin
        pick_fetch = i_req && (!d_req || fetch_first);
        pick_data  = d_req && !pick_fetch;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port fetch/data arbiter in front of the byte-addressable memory; one transaction
// per two cycles. Define MEM_ARBITER_RR_EN for round-robin instead of data priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
`ifndef MEM_ARBITER_RR_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  mode_q, mode_d;
    logic        we_q, we_d;
    logic        pick_fetch, pick_data;

`ifdef MEM_ARBITER_RR_EN
    owner_e last_owner_q, last_owner_d;
`else
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
`endif

    mem_arb_pick
`ifndef MEM_ARBITER_RR_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
    u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
`ifdef MEM_ARBITER_RR_EN
        .last_owner (last_owner_q),
`else
        .starve_cnt (starve_cnt_q),
`endif
        .pick_fetch (pick_fetch),
        .pick_data  (pick_data)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        we_d    = we_q;
`ifdef MEM_ARBITER_RR_EN
        last_owner_d = last_owner_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif
        bus.i_gnt      = 1'b0;
        bus.i_rvalid   = 1'b0;
        bus.i_rdata    = '0;
        bus.i_err      = 1'b0;
        bus.d_gnt      = 1'b0;
        bus.d_rvalid   = 1'b0;
        bus.d_rdata    = '0;
        bus.d_err      = 1'b0;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.mem_r_addr = '0;
        bus.mem_w_addr = '0;
        bus.mem_r_mode = MODE_SB;
        bus.mem_w_mode = MODE_SB;
        bus.mem_w_data = '0;
        bus.busy       = 1'b0;

        // Outputs held quiet while reset is asserted, including a RESP cycle.
        if (rst_n) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_fetch) begin
                        bus.i_gnt      = 1'b1;
                        bus.mem_r_en   = 1'b1;
                        bus.mem_r_addr = bus.i_addr;
                        bus.mem_r_mode = MODE_SW;
                        owner_d        = OWN_FETCH;
                        addr_d         = bus.i_addr;
                        mode_d         = MODE_SW;
                        we_d           = 1'b0;
                        state_d        = ARB_RESP;
`ifdef MEM_ARBITER_RR_EN
                        last_owner_d   = OWN_FETCH;
`else
                        starve_cnt_d   = '0;
`endif
                    end else if (pick_data) begin
                        bus.d_gnt = 1'b1;
                        if (bus.d_we) begin
                            bus.mem_w_en   = 1'b1;
                            bus.mem_w_addr = bus.d_addr;
                            bus.mem_w_mode = bus.d_mode;
                            bus.mem_w_data = bus.d_wdata;
                        end else begin
                            bus.mem_r_en   = 1'b1;
                            bus.mem_r_addr = bus.d_addr;
                            bus.mem_r_mode = bus.d_mode;
                        end
                        owner_d = OWN_DATA;
                        addr_d  = bus.d_addr;
                        mode_d  = bus.d_mode;
                        we_d    = bus.d_we;
                        state_d = ARB_RESP;
`ifdef MEM_ARBITER_RR_EN
                        last_owner_d = OWN_DATA;
`else
                        if (bus.i_req) starve_cnt_d = starve_cnt_q + CntW'(1);
`endif
                    end
                end
                ARB_RESP: begin
                    bus.busy = 1'b1;
                    // Memory aligns read data on the live address/mode, so keep them steady.
                    bus.mem_r_addr = addr_q;
                    bus.mem_r_mode = mode_q;
                    if (owner_q == OWN_FETCH) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.mem_r_data;
                        bus.i_err    = (bus.mem_state != MEMORY_STATE_OK);
                    end else begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = we_q ? 32'h0 : bus.mem_r_data;
                        bus.d_err    = (bus.mem_state != MEMORY_STATE_OK);
                    end
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_FETCH;
            addr_q  <= '0;
            mode_q  <= MODE_SB;
            we_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q <= OWN_FETCH;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q <= last_owner_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model with sticky alignment error, a table of
// single transactions, then contention and reset-in-RESP sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: little-endian bytes, zero-extended aligned reads, sticky misalignment.
    logic [7:0]  mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic        sticky_q;
    logic [7:0]  ra;
    logic [7:0]  wa;

    always_comb begin
        ra = bus.mem_r_addr[7:0];
        wa = bus.mem_w_addr[7:0];
        unique case (bus.mem_r_mode)
            MODE_SB: bus.mem_r_data = {24'h0, mem[ra]};
            MODE_SH: bus.mem_r_data = {16'h0, mem[ra + 8'd1], mem[ra]};
            default: bus.mem_r_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
        endcase
        bus.mem_state = sticky_q ? MEMORY_STATE_ALIGNMENT : MEMORY_STATE_OK;
    end

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) mem[pl_addr + 8'(i)] <= pl_data[8*i +: 8];
        end else if (bus.mem_w_en) begin
            mem[wa] <= bus.mem_w_data[7:0];
            if (bus.mem_w_mode != MODE_SB) mem[wa + 8'd1] <= bus.mem_w_data[15:8];
            if (bus.mem_w_mode == MODE_SW) begin
                mem[wa + 8'd2] <= bus.mem_w_data[23:16];
                mem[wa + 8'd3] <= bus.mem_w_data[31:24];
            end
        end
        if (!rst_n) sticky_q <= 1'b0;
        else if ((bus.mem_r_en && misaligned(bus.mem_r_addr, bus.mem_r_mode)) ||
                 (bus.mem_w_en && misaligned(bus.mem_w_addr, bus.mem_w_mode)))
            sticky_q <= 1'b1;
    end

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mode;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic [1:0] exp_mode;
        exp_mode = v.is_data ? v.mode : MODE_SW;
        @(negedge clk);
        if (v.is_data) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
            bus.d_mode  = v.mode;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        #1;
        check($sformatf("v%0d_gnt", idx), 32'({bus.i_gnt, bus.d_gnt}),
              v.is_data ? 32'd1 : 32'd2);
        check($sformatf("v%0d_en", idx), 32'({bus.mem_r_en, bus.mem_w_en}),
              v.we ? 32'd1 : 32'd2);
        if (v.we) begin
            check($sformatf("v%0d_waddr", idx), bus.mem_w_addr, v.addr);
            check($sformatf("v%0d_wmode", idx), 32'(bus.mem_w_mode), 32'(v.mode));
            check($sformatf("v%0d_wdata", idx), bus.mem_w_data, v.wdata);
        end else begin
            check($sformatf("v%0d_raddr", idx), bus.mem_r_addr, v.addr);
            check($sformatf("v%0d_rmode", idx), 32'(bus.mem_r_mode), 32'(exp_mode));
        end
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
        check($sformatf("v%0d_resp_gnt", idx), 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
        check($sformatf("v%0d_resp_en", idx), 32'({bus.mem_r_en, bus.mem_w_en}), 32'd0);
        check($sformatf("v%0d_rvalid", idx), 32'({bus.i_rvalid, bus.d_rvalid}),
              v.is_data ? 32'd1 : 32'd2);
        check($sformatf("v%0d_hold_addr", idx), bus.mem_r_addr, v.addr);
        check($sformatf("v%0d_hold_mode", idx), 32'(bus.mem_r_mode), 32'(exp_mode));
        check($sformatf("v%0d_rdata", idx), v.is_data ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        check($sformatf("v%0d_other_rdata", idx), v.is_data ? bus.i_rdata : bus.d_rdata, 32'h0);
        check($sformatf("v%0d_err", idx), 32'({bus.i_err, bus.d_err}),
              v.is_data ? 32'(v.exp_err) : 32'({v.exp_err, 1'b0}));
    endtask

    function automatic logic exp_fetch(input int k);
`ifdef MEM_ARBITER_RR_EN
        return (k % 2) == 1;
`else
        return (k % 5) == 4;
`endif
    endfunction

    // Both ports request back to back; ends during the RESP of the last grant.
    task automatic run_contend(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.i_req  = 1'b1;
            bus.i_addr = 32'h10;
            bus.d_req  = 1'b1;
            bus.d_we   = 1'b0;
            bus.d_addr = 32'h20;
            bus.d_mode = MODE_SW;
            #1;
            check($sformatf("%s_gnt%0d", tag, k), 32'({bus.i_gnt, bus.d_gnt}),
                  exp_fetch(k) ? 32'd2 : 32'd1);
            @(negedge clk);
            #1;
            check($sformatf("%s_wait%0d", tag, k), 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
            check($sformatf("%s_rv%0d", tag, k), 32'({bus.i_rvalid, bus.d_rvalid}),
                  exp_fetch(k) ? 32'd2 : 32'd1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h10;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h20;
        bus.d_wdata = '0;
        bus.d_mode = MODE_SW;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,    MODE_SW, 32'h0000_0013, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h21, 32'h0,    MODE_SB, 32'h0000_00CC, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h22, 32'h0,    MODE_SH, 32'h0000_AABB, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,    MODE_SW, 32'hAABB_CCDD, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h22, 32'h1234, MODE_SH, 32'h0,         1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h20, 32'h0,    MODE_SW, 32'h1234_CCDD, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h20, 32'h55,   MODE_SB, 32'h0,         1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h20, 32'h0,    MODE_SB, 32'h0000_0055, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h02, 32'h0,    MODE_SW, 32'h0,         1'b1};
        vecs[9] = '{1'b0, 1'b0, 32'h10, 32'h0,    MODE_SW, 32'h0000_0013, 1'b1};

        // Reset held with both requests high: nothing may be granted.
        preload(8'h00, 32'h0);
        preload(8'h04, 32'h0);
        preload(8'h10, 32'h0000_0013);
        preload(8'h20, 32'hAABB_CCDD);
        #1;
        check("rst_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
        check("rst_en", 32'({bus.mem_r_en, bus.mem_w_en}), 32'd0);

        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        rst_n = 1'b1;
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        check("idle_err", 32'({bus.i_err, bus.d_err}), 32'd0);
        check("idle_i_rdata", bus.i_rdata, 32'h0);
        check("idle_d_rdata", bus.d_rdata, 32'h0);
        check("idle_en", 32'({bus.mem_r_en, bus.mem_w_en}), 32'd0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Sticky error persists until reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn('{1'b0, 1'b0, 32'h10, 32'h0, MODE_SW, 32'h0000_0013, 1'b0}, 10);

        run_contend(10, "cont");
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;

        // Build up priority state, then reset during RESP.
        run_contend(3, "pre");
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check("rstresp_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        check("rstresp_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        run_contend(10, "after");
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
